// File: rtl/swc_rtu_pkg.sv
// Shared types, default parameters and helpers for the RTU response queue.
package swc_rtu_pkg;

    localparam int c_num_ports      = 7;
    localparam int c_prio_width     = 3;
    localparam int c_depth          = 4;
    localparam int c_filter_drop    = 1;
    localparam int c_max_ports      = 32;
    localparam int c_max_prio_width = 8;
    localparam int c_drop_cnt_width = 16;

    // Widths are the legal maxima; users keep only the low N / W bits.
    typedef struct packed {
        logic [c_max_ports-1:0]      mask;
        logic                        drop;
        logic [c_max_prio_width-1:0] prio;
    } t_rtu_rsp;

    // Ceiling log2, usable in constant expressions.
    function automatic int f_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/swc_rtu_rsp_queue_if.sv
// RTU-side and core-side response signals of the per-port response queue.
interface swc_rtu_rsp_queue_if
    import swc_rtu_pkg::*;
#(
    parameter int g_num_ports   = c_num_ports,
    parameter int g_prio_width  = c_prio_width,
    parameter int g_depth       = c_depth,
    parameter int g_filter_drop = c_filter_drop
);
    localparam int c_occ_width = f_log2(g_depth) + 1;

    logic [g_num_ports-1:0]                  rtu_rsp_valid_i;
    logic [g_num_ports-1:0]                  rtu_rsp_ack_o;
    logic [g_num_ports*g_num_ports-1:0]      rtu_dst_port_mask_i;
    logic [g_num_ports-1:0]                  rtu_drop_i;
    logic [g_num_ports*g_prio_width-1:0]     rtu_prio_i;
    logic [g_num_ports-1:0]                  core_rsp_valid_o;
    logic [g_num_ports-1:0]                  core_rsp_ack_i;
    logic [g_num_ports*g_num_ports-1:0]      core_dst_port_mask_o;
    logic [g_num_ports-1:0]                  core_drop_o;
    logic [g_num_ports*g_prio_width-1:0]     core_prio_o;
    logic [g_num_ports*c_occ_width-1:0]      occupancy_o;
    logic [g_num_ports*c_drop_cnt_width-1:0] drop_cnt_o;

    modport slave (
        input  rtu_rsp_valid_i, rtu_dst_port_mask_i, rtu_drop_i, rtu_prio_i, core_rsp_ack_i,
        output rtu_rsp_ack_o, core_rsp_valid_o, core_dst_port_mask_o, core_drop_o,
               core_prio_o, occupancy_o, drop_cnt_o
    );

    modport master (
        output rtu_rsp_valid_i, rtu_dst_port_mask_i, rtu_drop_i, rtu_prio_i, core_rsp_ack_i,
        input  rtu_rsp_ack_o, core_rsp_valid_o, core_dst_port_mask_o, core_drop_o,
               core_prio_o, occupancy_o, drop_cnt_o
    );

endinterface

// File: rtl/swc_rtu_rsp_queue_fifo.sv
// Single-port first-word-fall-through FIFO with registered occupancy.
module swc_rtu_rsp_fifo
    import swc_rtu_pkg::*;
#(
    parameter int g_width = 8,
    parameter int g_depth = c_depth
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        wr_i,
    input  logic [g_width-1:0]          wr_data_i,
    input  logic                        rd_i,
    output logic [g_width-1:0]          rd_data_o,
    output logic                        valid_o,
    output logic                        full_o,
    output logic [f_log2(g_depth):0]    occupancy_o
);
    localparam int c_ptr_width = f_log2(g_depth);

    logic [g_width-1:0]     mem [g_depth];
    logic [c_ptr_width-1:0] wr_ptr;
    logic [c_ptr_width-1:0] rd_ptr;
    logic [c_ptr_width-1:0] rd_addr;
    logic [c_ptr_width:0]   count;
    logic                   do_wr;
    logic                   do_rd;

    assign full_o      = (count == (c_ptr_width + 1)'(g_depth));
    assign valid_o     = (count != '0);
    assign occupancy_o = count;
    assign do_wr       = wr_i & ~full_o;
    assign do_rd       = rd_i & valid_o;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; clearing the pointers and count already discards every entry.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem[wr_ptr] <= wr_data_i;
    end

    // Empty queue keeps presenting the slot consumed last.
    assign rd_addr   = valid_o ? rd_ptr : rd_ptr - 1'b1;
    assign rd_data_o = mem[rd_addr];

endmodule

// File: rtl/swc_rtu_rsp_queue.sv
// Per-port RTU response queues with optional absorption and counting of drop responses.
module swc_rtu_rsp_queue
    import swc_rtu_pkg::*;
#(
    parameter int g_num_ports   = c_num_ports,
    parameter int g_prio_width  = c_prio_width,
    parameter int g_depth       = c_depth,
    parameter int g_filter_drop = c_filter_drop
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    swc_rtu_rsp_queue_if.slave bus
);
    localparam int c_occ_width   = f_log2(g_depth) + 1;
    localparam int c_entry_width = g_num_ports + 1 + g_prio_width;

    logic [g_num_ports-1:0] full;
    logic [g_num_ports-1:0] absorb;
    logic [g_num_ports-1:0] wr;

    assign absorb = (g_filter_drop != 0) ? bus.rtu_drop_i : '0;

    // Registered full reads 0 during reset, so reset gates the ack explicitly.
    assign bus.rtu_rsp_ack_o = {g_num_ports{rst_n_i}} & bus.rtu_rsp_valid_i & (~full | absorb);
    assign wr                = bus.rtu_rsp_ack_o & ~absorb;

    for (genvar i = 0; i < g_num_ports; i++) begin : g_port
        logic [c_entry_width-1:0]    wr_data;
        logic [c_entry_width-1:0]    rd_data;
        logic [c_occ_width-1:0]      occupancy;
        logic [c_drop_cnt_width-1:0] drop_cnt;

        assign wr_data = {bus.rtu_dst_port_mask_i[i*g_num_ports +: g_num_ports],
                          bus.rtu_drop_i[i],
                          bus.rtu_prio_i[i*g_prio_width +: g_prio_width]};

        swc_rtu_rsp_fifo #(
            .g_width (c_entry_width),
            .g_depth (g_depth)
        ) u_fifo (
            .clk_i       (clk_i),
            .rst_n_i     (rst_n_i),
            .wr_i        (wr[i]),
            .wr_data_i   (wr_data),
            .rd_i        (bus.core_rsp_ack_i[i]),
            .rd_data_o   (rd_data),
            .valid_o     (bus.core_rsp_valid_o[i]),
            .full_o      (full[i]),
            .occupancy_o (occupancy)
        );

        assign {bus.core_dst_port_mask_o[i*g_num_ports +: g_num_ports],
                bus.core_drop_o[i],
                bus.core_prio_o[i*g_prio_width +: g_prio_width]} = rd_data;
        assign bus.occupancy_o[i*c_occ_width +: c_occ_width]           = occupancy;
        assign bus.drop_cnt_o[i*c_drop_cnt_width +: c_drop_cnt_width]  = drop_cnt;

        // Saturating count of accepted-and-absorbed drop responses.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                drop_cnt <= '0;
            end else if (bus.rtu_rsp_ack_o[i] && absorb[i] && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_swc_rtu_rsp_queue.sv
// Randomised and directed bench for swc_rtu_rsp_queue against a queue-based reference model.
module tb_swc_rtu_rsp_queue;
    import swc_rtu_pkg::*;

    localparam int N  = 7;
    localparam int W  = 3;
    localparam int D  = 4;
    localparam int OW = f_log2(D) + 1;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [N-1:0]   rv    = '0;
    logic [N-1:0]   rdrop = '0;
    logic [N-1:0]   cack  = '0;
    logic [N*N-1:0] rmask = '0;
    logic [N*W-1:0] rprio = '0;

    // Instance 0 absorbs drops, instance 1 queues them.
    swc_rtu_rsp_queue_if #(.g_num_ports(N), .g_prio_width(W), .g_depth(D), .g_filter_drop(1)) bus_f ();
    swc_rtu_rsp_queue_if #(.g_num_ports(N), .g_prio_width(W), .g_depth(D), .g_filter_drop(0)) bus_q ();

    swc_rtu_rsp_queue #(.g_num_ports(N), .g_prio_width(W), .g_depth(D), .g_filter_drop(1)) u_dut_f (
        .clk_i (clk_i), .rst_n_i (rst_n_i), .bus (bus_f.slave));
    swc_rtu_rsp_queue #(.g_num_ports(N), .g_prio_width(W), .g_depth(D), .g_filter_drop(0)) u_dut_q (
        .clk_i (clk_i), .rst_n_i (rst_n_i), .bus (bus_q.slave));

    assign bus_f.rtu_rsp_valid_i     = rv;
    assign bus_f.rtu_drop_i          = rdrop;
    assign bus_f.rtu_dst_port_mask_i = rmask;
    assign bus_f.rtu_prio_i          = rprio;
    assign bus_f.core_rsp_ack_i      = cack;
    assign bus_q.rtu_rsp_valid_i     = rv;
    assign bus_q.rtu_drop_i          = rdrop;
    assign bus_q.rtu_dst_port_mask_i = rmask;
    assign bus_q.rtu_prio_i          = rprio;
    assign bus_q.core_rsp_ack_i      = cack;

    t_rtu_rsp    mq   [2][N][$];
    int unsigned mcnt [2][N];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                mq[k][i].delete();
                mcnt[k][i] = 0;
            end
        end
    endtask

    // Advance the model by one clock edge using the inputs that were present before it.
    task automatic model_update();
        if (!rst_n_i) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                int       sz;
                bit       absorb;
                bit       acc;
                t_rtu_rsp e;
                sz     = mq[k][i].size();
                absorb = (k == 0) && rdrop[i];
                acc    = rv[i] && (sz < D || absorb);
                if (acc && absorb) begin
                    if (mcnt[k][i] < 65535) mcnt[k][i]++;
                end else if (acc) begin
                    e               = '0;
                    e.mask[N-1:0]   = rmask[i*N +: N];
                    e.drop          = rdrop[i];
                    e.prio[W-1:0]   = rprio[i*W +: W];
                    mq[k][i].push_back(e);
                end
                if (cack[i] && sz != 0) void'(mq[k][i].pop_front());
            end
        end
    endtask

    task automatic compare_inst(input int k, input string nm,
                                input logic [N-1:0] ack, input logic [N-1:0] vld,
                                input logic [N*OW-1:0] occ, input logic [N*16-1:0] cnt,
                                input logic [N*N-1:0] mask, input logic [N-1:0] drp,
                                input logic [N*W-1:0] prio);
        logic [N-1:0]    e_ack, e_vld, e_drp, o_drp;
        logic [N*OW-1:0] e_occ;
        logic [N*16-1:0] e_cnt;
        logic [N*N-1:0]  e_mask, o_mask;
        logic [N*W-1:0]  e_prio, o_prio;
        e_ack = '0; e_vld = '0; e_drp = '0; o_drp = '0; e_occ = '0; e_cnt = '0;
        e_mask = '0; o_mask = '0; e_prio = '0; o_prio = '0;
        for (int i = 0; i < N; i++) begin
            int sz;
            sz = mq[k][i].size();
            e_ack[i]           = rst_n_i && rv[i] && (sz < D || (k == 0 && rdrop[i]));
            e_vld[i]           = (sz != 0);
            e_occ[i*OW +: OW]  = OW'(sz);
            e_cnt[i*16 +: 16]  = 16'(mcnt[k][i]);
            if (sz != 0) begin
                e_mask[i*N +: N] = mq[k][i][0].mask[N-1:0];
                e_drp[i]         = mq[k][i][0].drop;
                e_prio[i*W +: W] = mq[k][i][0].prio[W-1:0];
                o_mask[i*N +: N] = mask[i*N +: N];
                o_drp[i]         = drp[i];
                o_prio[i*W +: W] = prio[i*W +: W];
            end
        end
        check({nm, "_ack"},   128'(ack),    128'(e_ack));
        check({nm, "_valid"}, 128'(vld),    128'(e_vld));
        check({nm, "_occ"},   128'(occ),    128'(e_occ));
        check({nm, "_dcnt"},  128'(cnt),    128'(e_cnt));
        check({nm, "_mask"},  128'(o_mask), 128'(e_mask));
        check({nm, "_drop"},  128'(o_drp),  128'(e_drp));
        check({nm, "_prio"},  128'(o_prio), 128'(e_prio));
    endtask

    task automatic compare_all();
        compare_inst(0, "filt", bus_f.rtu_rsp_ack_o, bus_f.core_rsp_valid_o, bus_f.occupancy_o,
                     bus_f.drop_cnt_o, bus_f.core_dst_port_mask_o, bus_f.core_drop_o, bus_f.core_prio_o);
        compare_inst(1, "nofilt", bus_q.rtu_rsp_ack_o, bus_q.core_rsp_valid_o, bus_q.occupancy_o,
                     bus_q.drop_cnt_o, bus_q.core_dst_port_mask_o, bus_q.core_drop_o, bus_q.core_prio_o);
    endtask

    // Inputs are set just after a falling edge; compare, take the rising edge, update the model.
    task automatic cycle();
        #1;
        compare_all();
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
    endtask

    task automatic idle();
        rv = '0; rdrop = '0; cack = '0;
    endtask

    task automatic set_port(input int i, input logic v, input logic [N-1:0] m,
                            input logic d, input logic [W-1:0] p);
        rv[i]            = v;
        rmask[i*N +: N]  = m;
        rdrop[i]         = d;
        rprio[i*W +: W]  = p;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        int got;
        bit exp_acc;
        model_reset();
        @(negedge clk_i);

        // Held in reset with every valid high: nothing acknowledged, nothing queued.
        rv = '1; rdrop = 7'h2a;
        repeat (3) cycle();
        check("reset_ack", 128'(bus_f.rtu_rsp_ack_o), 128'(0));
        rst_n_i = 1'b1;
        idle();
        cycle();

        // Fill port 2: four acks, then refused; head is entry 0.
        for (int j = 0; j < 5; j++) begin
            set_port(2, 1'b1, 7'(j * 9 + 3), 1'b0, 3'(j));
            cycle();
        end
        check("fill_occ2",  128'(bus_f.occupancy_o[2*OW +: OW]), 128'(4));
        check("fill_ack2",  128'(bus_f.rtu_rsp_ack_o[2]), 128'(0));
        check("fill_vld2",  128'(bus_f.core_rsp_valid_o[2]), 128'(1));
        check("fill_mask2", 128'(bus_f.core_dst_port_mask_o[2*N +: N]), 128'(3));
        check("fill_prio2", 128'(bus_f.core_prio_o[2*W +: W]), 128'(0));

        // Full plus read in the same cycle: write refused, then accepted next cycle.
        cack[2] = 1'b1;
        set_port(2, 1'b1, 7'h55, 1'b0, 3'd6);
        cycle();
        cack[2] = 1'b0;
        check("fullrd_occ2", 128'(bus_f.occupancy_o[2*OW +: OW]), 128'(3));
        check("fullrd_ack2", 128'(bus_f.rtu_rsp_ack_o[2]), 128'(1));
        cycle();
        check("fullrd_occ2b", 128'(bus_f.occupancy_o[2*OW +: OW]), 128'(4));
        idle(); cack[2] = 1'b1;
        repeat (5) cycle();
        check("drain_occ2", 128'(bus_f.occupancy_o[2*OW +: OW]), 128'(0));
        idle();

        // Drop absorption on a full port 5, then counter saturation.
        for (int j = 0; j < 4; j++) begin
            set_port(5, 1'b1, 7'(j + 16), 1'b0, 3'(j));
            cycle();
        end
        rdrop[5] = 1'b1;
        cycle();
        check("drop_cnt5",  128'(bus_f.drop_cnt_o[5*16 +: 16]), 128'(1));
        check("drop_occ5",  128'(bus_f.occupancy_o[5*OW +: OW]), 128'(4));
        check("drop_cnt5q", 128'(bus_q.drop_cnt_o[5*16 +: 16]), 128'(0));
        repeat (65539) cycle();
        check("drop_sat5",  128'(bus_f.drop_cnt_o[5*16 +: 16]), 128'(16'hffff));
        idle(); cack[5] = 1'b1;
        repeat (4) cycle();
        idle();

        // Ordered stream through port 0 under random core ack.
        sent = 0; got = 0;
        for (int c = 0; c < 300 && (sent < 10 || mq[0][0].size() != 0); c++) begin
            if (sent < 10) set_port(0, 1'b1, 7'(sent * 13 + 1), 1'b0, 3'(sent % 8));
            else rv[0] = 1'b0;
            cack[0] = 1'($urandom_range(0, 1));
            exp_acc = (sent < 10) && (mq[0][0].size() < D);
            if (cack[0] && mq[0][0].size() != 0) begin
                check("stream_prio", 128'(bus_f.core_prio_o[2:0]), 128'(got % 8));
                got++;
            end
            cycle();
            if (exp_acc) sent++;
        end
        check("stream_sent", 128'(sent), 128'(10));
        check("stream_got",  128'(got),  128'(10));
        idle();

        // Every port writes its own one-hot mask in the same cycle.
        for (int i = 0; i < N; i++) set_port(i, 1'b1, 7'(1 << i), 1'b0, 3'(i));
        cycle();
        idle();
        for (int i = 0; i < N; i++) begin
            check("indep_mask", 128'(bus_f.core_dst_port_mask_o[i*N +: N]), 128'(1 << i));
        end
        check("indep_vld", 128'(bus_f.core_rsp_valid_o), 128'(7'h7f));
        cack = '1;
        cycle();
        idle();

        // Random traffic on all ports.
        for (int c = 0; c < 3000; c++) begin
            rv    = N'($urandom);
            rdrop = N'($urandom & $urandom);
            rmask = (N*N)'({$urandom, $urandom});
            rprio = (N*W)'($urandom);
            cack  = N'($urandom);
            cycle();
        end

        // Reset mid-stream with 3 entries queued on port 3.
        idle(); cack = '1;
        repeat (5) cycle();
        idle();
        for (int j = 0; j < 3; j++) begin
            set_port(3, 1'b1, 7'(j + 40), 1'b0, 3'(j));
            set_port(1, j == 0, 7'h01, 1'b1, 3'd0);
            cycle();
        end
        check("pre_rst_occ3", 128'(bus_f.occupancy_o[3*OW +: OW]), 128'(3));
        rv[3] = 1'b1;
        rst_n_i = 1'b0;
        model_reset();
        #1;
        check("rst_ack",  128'(bus_f.rtu_rsp_ack_o),    128'(0));
        check("rst_vld",  128'(bus_f.core_rsp_valid_o), 128'(0));
        check("rst_occ",  128'(bus_f.occupancy_o),      128'(0));
        cycle();
        rst_n_i = 1'b1;
        idle();
        cycle();
        check("post_rst_occ",  128'(bus_f.occupancy_o), 128'(0));
        check("post_rst_dcnt", 128'(bus_f.drop_cnt_o),  128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
